ctrl_reg_bank: RTL

Parametrised memory-mapped control register bank for the IO controller, sitting between the bus slave interface and the robot-control/interrupt logic. It holds NUM_REGS general control registers, a sticky interrupt status register and an interrupt mask. It provides per-register write strobes, a global done pulse, registered readback, and a level interrupt output.

---
 rtl/ctrl_reg_bank.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ctrl_reg_bank.sv
// Memory-mapped control register bank: NUM_REGS CTRL registers plus optional sticky IRQ status/mask.
// Interrupt logic is built only when CTRL_REG_BANK_IRQ_EN is defined; otherwise addresses 0/1 are unmapped.

module ctrl_reg_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  wr_pulse
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      if (wr_en) q <= wr_data;
    end
  end
endmodule

module ctrl_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 2,
  parameter int ADDR_W     = 4,
  parameter int NUM_IRQ    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic                           re,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           done,
  input  logic [NUM_IRQ-1:0]             irq_src,
  output logic                           irq
);
  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] data;
  } bus_req_t;

  bus_req_t req;
  assign req.we   = we;
  assign req.re   = re;
  assign req.addr = addr;
  assign req.data = wr_data;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [NUM_REGS-1:0]                 ctrl_hit;
  logic                                stat_hit, mask_hit;
  logic [NUM_IRQ-1:0]                  irq_status, irq_mask;
  logic [DATA_WIDTH-1:0]               rd_mux;

  // CTRL[i] lives at address i+2
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lane
    assign ctrl_hit[i] = (req.addr == ADDR_W'(i + 2));
    ctrl_reg_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (req.we & ctrl_hit[i]),
      .wr_data  (req.data),
      .q        (ctrl_q[i]),
      .wr_pulse (wr_pulse[i])
    );
  end

  assign ctrl_out = ctrl_q;

`ifdef CTRL_REG_BANK_IRQ_EN
  logic [NUM_IRQ-1:0] irq_src_q, irq_rise, irq_w1c;

  assign stat_hit = (req.addr == ADDR_W'(0));
  assign mask_hit = (req.addr == ADDR_W'(1));
  assign irq_rise = irq_src & ~irq_src_q;
  assign irq_w1c  = (req.we && stat_hit) ? req.data[NUM_IRQ-1:0] : '0;

  // Clear first, then OR in new events so a same-edge set beats W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_src_q  <= '0;
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      irq_src_q  <= irq_src;
      irq_status <= (irq_status & ~irq_w1c) | irq_rise;
      if (req.we && mask_hit) irq_mask <= req.data[NUM_IRQ-1:0];
      irq        <= |(irq_status & irq_mask);
    end
  end
`else
  logic unused_irq_src;

  assign stat_hit       = 1'b0;
  assign mask_hit       = 1'b0;
  assign irq_status     = '0;
  assign irq_mask       = '0;
  assign irq            = 1'b0;
  assign unused_irq_src = ^irq_src;
`endif

  always_comb begin
    rd_mux = '0;
    if (stat_hit) rd_mux[NUM_IRQ-1:0] = irq_status;
    if (mask_hit) rd_mux[NUM_IRQ-1:0] = irq_mask;
    for (int i = 0; i < NUM_REGS; i++)
      if (ctrl_hit[i]) rd_mux = ctrl_q[i];
  end

  // Reads sample current (pre-write) contents, so a same-edge write is not visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= req.re;
      if (req.re) rd_data <= rd_mux;
      done     <= req.we & (|ctrl_hit | stat_hit | mask_hit);
    end
  end
endmodule
